// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt input conditioner and the
// APB interrupt controller.
package irq_pkg;

    localparam logic [1:0] IRQ_MODE_RISE  = 2'b00;
    localparam logic [1:0] IRQ_MODE_FALL  = 2'b01;
    localparam logic [1:0] IRQ_MODE_BOTH  = 2'b10;
    localparam logic [1:0] IRQ_MODE_LEVEL = 2'b11;

    localparam int IRQ_NUM_DEFAULT = 4;

endpackage

// File: rtl/irq_input_conditioner_if.sv
// Configuration, raw-line and conditioned-output bundle of the
// interrupt input conditioner.
interface irq_input_conditioner_if #(
    parameter int NUM_IRQ   = 4,
    parameter int DEB_CNT_W = 8
);

    logic                   enable_i;
    logic [NUM_IRQ-1:0]     irq_raw_i;
    logic [2*NUM_IRQ-1:0]   mode_i;
    logic [DEB_CNT_W-1:0]   deb_cycles_i;
    logic [NUM_IRQ-1:0]     irq_trigger_o;
    logic [NUM_IRQ-1:0]     filt_level_o;

    modport master (
        output enable_i,
        output irq_raw_i,
        output mode_i,
        output deb_cycles_i,
        input  irq_trigger_o,
        input  filt_level_o
    );

    modport slave (
        input  enable_i,
        input  irq_raw_i,
        input  mode_i,
        input  deb_cycles_i,
        output irq_trigger_o,
        output filt_level_o
    );

endinterface

// File: rtl/irq_glitch_filter.sv
// One interrupt line: synchroniser, stable-count glitch filter and
// registered edge/level trigger generation.
module irq_glitch_filter
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT_W   = 8
) (
    input  logic                 pclk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 raw_i,
    input  logic [1:0]           mode_i,
    input  logic [DEB_CNT_W-1:0] deb_cycles_i,
    output logic                 trigger_o,
    output logic                 level_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;
    logic                   lvl_q;
    logic                   lvl_d;
    logic [DEB_CNT_W-1:0]   cnt_q;
    logic [DEB_CNT_W-1:0]   cnt_d;
    logic                   trig_q;
    logic                   trig_d;
    logic [DEB_CNT_W:0]     deb_eff;
    logic [DEB_CNT_W:0]     cnt_inc;
    logic                   rise;
    logic                   fall;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign s      = sync_q[SYNC_STAGES-1];

    // Compare one bit wider than the counter so D=255 never wraps.
    always_comb begin
        deb_eff = (deb_cycles_i == '0) ? (DEB_CNT_W+1)'(1)
                                       : {1'b0, deb_cycles_i};
        cnt_inc = {1'b0, cnt_q} + (DEB_CNT_W+1)'(1);
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        rise    = 1'b0;
        fall    = 1'b0;
        if (enable_i) begin
            if (s == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_inc >= deb_eff) begin
                lvl_d = s;
                cnt_d = '0;
                rise  = s;
                fall  = ~s;
            end else begin
                cnt_d = cnt_inc[DEB_CNT_W-1:0];
            end
        end
    end

    always_comb begin
        trig_d = 1'b0;
        if (enable_i) begin
            unique case (mode_i)
                IRQ_MODE_RISE:  trig_d = rise;
                IRQ_MODE_FALL:  trig_d = fall;
                IRQ_MODE_BOTH:  trig_d = rise | fall;
                IRQ_MODE_LEVEL: trig_d = lvl_d;
            endcase
        end
    end

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
            cnt_q  <= '0;
            trig_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            trig_q <= trig_d;
        end
    end

    assign trigger_o = trig_q;
    assign level_o   = lvl_q;

endmodule

// File: rtl/irq_input_conditioner.sv
// Per-line synchronise, debounce and edge/level conversion of raw
// peripheral interrupts ahead of the interrupt controller.
module irq_input_conditioner
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = IRQ_NUM_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT_W   = 8
) (
    input  logic                    pclk_i,
    input  logic                    rst_i,
    irq_input_conditioner_if.slave  bus
);

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        irq_glitch_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CNT_W   (DEB_CNT_W)
        ) u_filt (
            .pclk_i       (pclk_i),
            .rst_i        (rst_i),
            .enable_i     (bus.enable_i),
            .raw_i        (bus.irq_raw_i[i]),
            .mode_i       (bus.mode_i[2*i +: 2]),
            .deb_cycles_i (bus.deb_cycles_i),
            .trigger_o    (bus.irq_trigger_o[i]),
            .level_o      (bus.filt_level_o[i])
        );
    end

endmodule

// File: tb/tb_irq_input_conditioner.sv
// Directed and random checks of irq_input_conditioner against a
// sample-history reference model.
module tb_irq_input_conditioner;

    localparam int N  = 4;
    localparam int SY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    irq_input_conditioner_if #(.NUM_IRQ(N), .DEB_CNT_W(8)) bus ();

    irq_input_conditioner #(
        .NUM_IRQ     (N),
        .SYNC_STAGES (SY),
        .DEB_CNT_W   (8)
    ) dut (
        .pclk_i (clk),
        .rst_i  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [N-1:0] pipe [$];
    int           run [N];
    logic [N-1:0] lvl_m;
    logic [N-1:0] trig_m;

    task automatic model_reset();
        pipe.delete();
        for (int k = 0; k < SY; k++) pipe.push_back('0);
        for (int k = 0; k < N; k++) run[k] = 0;
        lvl_m  = '0;
        trig_m = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] s;
        logic [N-1:0] ev_r;
        logic [N-1:0] ev_f;
        logic [1:0]   md;
        int           d;
        if (rst) begin
            model_reset();
            return;
        end
        s = pipe.pop_front();
        pipe.push_back(bus.irq_raw_i);
        d = (bus.deb_cycles_i == 0) ? 1 : int'(bus.deb_cycles_i);
        ev_r = '0;
        ev_f = '0;
        for (int k = 0; k < N; k++) begin
            if (!bus.enable_i) continue;
            if (s[k] == lvl_m[k]) begin
                run[k] = 0;
            end else begin
                run[k]++;
                if (run[k] >= d) begin
                    lvl_m[k] = s[k];
                    run[k]   = 0;
                    if (s[k]) ev_r[k] = 1'b1;
                    else      ev_f[k] = 1'b1;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            md = bus.mode_i[2*k +: 2];
            case (md)
                2'b00:   trig_m[k] = ev_r[k];
                2'b01:   trig_m[k] = ev_f[k];
                2'b10:   trig_m[k] = ev_r[k] | ev_f[k];
                default: trig_m[k] = lvl_m[k];
            endcase
            if (!bus.enable_i) trig_m[k] = 1'b0;
        end
    endtask

    task automatic chk(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_trig", bus.irq_trigger_o, trig_m);
        chk("model_lvl", bus.filt_level_o, lvl_m);
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        model_reset();
        bus.enable_i     = 1'b1;
        bus.irq_raw_i    = '0;
        bus.mode_i       = '0;
        bus.deb_cycles_i = 8'd3;

        // Reset, then a clean rising step on line 0 with D=3
        ticks(2);
        chk("rst_trig", bus.irq_trigger_o, 4'b0000);
        chk("rst_lvl", bus.filt_level_o, 4'b0000);
        rst = 1'b0;
        ticks(3);
        bus.irq_raw_i = 4'b0001;
        ticks(4);
        chk("rise_early", bus.irq_trigger_o, 4'b0000);
        tick();
        chk("rise_pulse", bus.irq_trigger_o, 4'b0001);
        chk("rise_lvl", bus.filt_level_o, 4'b0001);
        tick();
        chk("rise_end", bus.irq_trigger_o, 4'b0000);

        // Short pulses on line 1 must be rejected with D=4
        bus.deb_cycles_i = 8'd4;
        for (int r = 0; r < 2; r++) begin
            bus.irq_raw_i = 4'b0011;
            ticks(3);
            bus.irq_raw_i = 4'b0001;
            ticks(8);
            chk("glitch_trig", bus.irq_trigger_o, 4'b0000);
            chk("glitch_lvl", bus.filt_level_o, 4'b0001);
        end

        // Line 2 both-edges, line 3 level, D=1
        bus.mode_i       = 8'hE0;
        bus.deb_cycles_i = 8'd1;
        bus.irq_raw_i    = 4'b1101;
        ticks(3);
        chk("both_rise", bus.irq_trigger_o, 4'b1100);
        tick();
        chk("both_gap", bus.irq_trigger_o, 4'b1000);
        ticks(6);
        bus.irq_raw_i = 4'b1001;
        ticks(2);
        chk("both_hold", bus.irq_trigger_o, 4'b1000);
        tick();
        chk("both_fall", bus.irq_trigger_o, 4'b1100);
        tick();
        chk("both_after", bus.irq_trigger_o, 4'b1000);
        bus.irq_raw_i = 4'b0001;
        ticks(4);
        chk("level_drop", bus.irq_trigger_o, 4'b0000);

        // Disable mid-filter on line 0, D=2
        bus.mode_i       = 8'h00;
        bus.deb_cycles_i = 8'd2;
        bus.irq_raw_i    = 4'b0000;
        ticks(6);
        chk("en_pre_lvl", bus.filt_level_o, 4'b0000);
        bus.irq_raw_i = 4'b0001;
        ticks(3);
        bus.enable_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("dis_trig", bus.irq_trigger_o, 4'b0000);
            chk("dis_lvl", bus.filt_level_o, 4'b0000);
        end
        bus.enable_i = 1'b1;
        tick();
        chk("reen_pulse", bus.irq_trigger_o, 4'b0001);
        tick();
        chk("reen_end", bus.irq_trigger_o, 4'b0000);

        // Lines high through reset, D=0 treated as 1
        rst              = 1'b1;
        bus.irq_raw_i    = 4'b1111;
        bus.deb_cycles_i = 8'd0;
        model_reset();
        #1;
        chk("arst_lvl", bus.filt_level_o, 4'b0000);
        ticks(2);
        rst = 1'b0;
        ticks(2);
        chk("hi_rst_early", bus.irq_trigger_o, 4'b0000);
        tick();
        chk("hi_rst_pulse", bus.irq_trigger_o, 4'b1111);
        chk("hi_rst_lvl", bus.filt_level_o, 4'b1111);

        // Asynchronous reset while filtering a fall
        bus.deb_cycles_i = 8'd5;
        bus.irq_raw_i    = 4'b0000;
        ticks(3);
        chk("mid_lvl", bus.filt_level_o, 4'b1111);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_trig", bus.irq_trigger_o, 4'b0000);
        chk("mid_rst_lvl", bus.filt_level_o, 4'b0000);
        tick();
        rst = 1'b0;

        // Rising-to-falling mode switch while S=1
        bus.deb_cycles_i = 8'd3;
        bus.irq_raw_i    = 4'b0001;
        ticks(6);
        bus.mode_i = 8'h01;
        ticks(3);
        chk("sw_none", bus.irq_trigger_o, 4'b0000);
        bus.irq_raw_i = 4'b0000;
        ticks(4);
        chk("sw_early", bus.irq_trigger_o, 4'b0000);
        tick();
        chk("sw_pulse", bus.irq_trigger_o, 4'b0001);
        tick();
        chk("sw_end", bus.irq_trigger_o, 4'b0000);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0)
                bus.irq_raw_i[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0)
                bus.deb_cycles_i = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 60) == 0)
                bus.mode_i = 8'($urandom);
            bus.enable_i = ($urandom_range(0, 15) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_input_conditioner.md
Name: irq_input_conditioner

Overview:
- Front-end stage feeding the APB interrupt controller's `irq_trigger_i`.
- Takes raw, asynchronous peripheral interrupt lines and synchronises each one into `pclk_i`.
- Glitch-filters each line with a programmable stable-cycle count.
- Converts each line into clean single-cycle event pulses or a clean level, selected per line.

Parameters:
- NUM_IRQ, 4, number of interrupt lines (matches controller width).
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (minimum 2).
- DEB_CNT_W, 8, width of the debounce counter and of `deb_cycles_i`.

Ports:
- pclk_i  input  1  system/APB clock; single clock domain.
- rst_i  input  1  asynchronous, active-high reset.
- enable_i  input  1  global enable; same meaning as the controller's enable.
- irq_raw_i  input  NUM_IRQ  raw asynchronous interrupt lines.
- mode_i  input  2*NUM_IRQ  per-line mode, bits [2i+1:2i]: 00 rising, 01 falling, 10 both edges, 11 level.
- deb_cycles_i  input  DEB_CNT_W  consecutive differing samples required before a line changes state; 0 is treated as 1.
- irq_trigger_o  output  NUM_IRQ  conditioned interrupt, connects to controller `irq_trigger_i`.
- filt_level_o  output  NUM_IRQ  current filtered (stable) level per line, for debug/readback.

Behaviour:
- Reset (rst_i=1, asynchronous, any time):
  - All synchroniser flops, stable levels S[i], counters cnt[i], `irq_trigger_o` and `filt_level_o` go to 0 immediately.
  - Reset mid-filter discards any partial count.
- Synchroniser:
  - SYNC_STAGES-flop chain per line, always clocked; it ignores `enable_i`.
  - Output s[i] lags `irq_raw_i` by SYNC_STAGES edges.
- Filter, per line, at each `pclk_i` edge with enable_i=1:
  - Let D = max(deb_cycles_i, 1).
  - If s[i]==S[i]: cnt[i] <= 0.
  - Else if cnt[i]+1 >= D: S[i] <= s[i]; cnt[i] <= 0; a transition event is flagged.
  - Else: cnt[i] <= cnt[i]+1.
- Filter state machine:
  - Effective states are STABLE_LOW, FILT_RISE, STABLE_HIGH, FILT_FALL, encoded by (S, cnt!=0).
  - STABLE_LOW -> FILT_RISE when s=1 and D>1, or straight to STABLE_HIGH when D=1.
  - FILT_RISE -> STABLE_LOW on any s=0 sample (glitch rejected).
  - FILT_RISE -> STABLE_HIGH after D consecutive s=1 samples.
  - The falling path is symmetric.
- Output generation (registered):
  - Rising mode: irq_trigger_o[i]=1 for exactly the one cycle after S goes 0->1.
  - Falling mode: same, for S going 1->0.
  - Both-edges mode: pulse on either transition.
  - Level mode: irq_trigger_o[i] equals S[i].
  - filt_level_o[i] equals S[i] in every mode.
- Latency: a clean input step reaches `irq_trigger_o` SYNC_STAGES + D edges after the first edge that samples the new level.
- enable_i=0:
  - Filter state, counters and S hold.
  - irq_trigger_o is forced to 0 in every mode.
  - filt_level_o keeps showing S.
  - Edges are not lost: a pending difference resolves after enable returns.
- Config changes:
  - `mode_i` takes effect on the next edge. A mode change never produces a pulse by itself; pulses come only from S transitions.
  - If `deb_cycles_i` is lowered below the current cnt, the line flips on the next differing sample.
  - Counter compare is done at DEB_CNT_W+1 bits, so there is no wrap at the max value (255).
- Line high at reset release: treated as a rising transition after SYNC_STAGES + D edges.
- Lines are fully independent; simultaneous events on several lines produce simultaneous pulses.

Decomposition:
- Package irq_pkg holds:
  - mode localparams IRQ_MODE_RISE=2'b00, IRQ_MODE_FALL=2'b01, IRQ_MODE_BOTH=2'b10, IRQ_MODE_LEVEL=2'b11;
  - the default NUM_IRQ.
  - The interrupt controller shares this package.
- Sub-module irq_glitch_filter (one line: synchroniser, counter, S, event/level output), instantiated NUM_IRQ times through a generate loop.

Test Plan:
- Reset with irq_raw_i=4'b0000, deb=3, all rising; raise irq_raw_i[0] and hold -> irq_trigger_o=4'b0001 for exactly one cycle, 2+3 edges after first sampling; filt_level_o[0]=1.
- deb=4; drive irq_raw_i[1] high for 3 cycles then low -> irq_trigger_o and filt_level_o[1] stay 0 (glitch rejected); cnt returns to 0.
- Line 2 in mode 10, deb=1; apply a 0->1->0 step with 10 cycles between edges -> two single-cycle pulses, 10 cycles apart; line 3 in mode 11 held high -> irq_trigger_o[3] stays 1 for the whole high period.
- deb=2, rising; drop enable_i during filtering of a rising step on line 0, hold 5 cycles, re-enable -> no output while disabled; one pulse after re-enable once the remaining count completes.
- irq_raw_i=4'b1111 held through reset, deb=0 -> after rst_i falls, all four lines pulse on the same cycle, SYNC_STAGES+1 edges later; assert rst_i mid-filter -> all outputs drop to 0 asynchronously.
- Switch line 0 from rising to falling while S=1 -> no pulse at the switch; one pulse D+2 edges after irq_raw_i[0] falls.
